// File: rtl/video_frame_check.sv
// video_frame_check: measures active geometry and a CRC-16 of every video
// frame, reports them one cycle after each frame start, and tracks geometry
// lock plus sticky protocol errors.
//
// Ports:
//   clk_pix      pixel clock (only clock)
//   rst_pix      asynchronous active-high reset
//   disp_x       signed horizontal position of the current pixel
//   disp_de      data enable, low during blanking
//   disp_frame   one-cycle frame-start strobe
//   disp_r/g/b   colour channels, BPC bits each
//   err_clr      one-cycle clear of the sticky error flags
//   frame_done   one-cycle pulse when the results below are updated
//   meas_width   active pixels per line of the last reported frame
//   meas_height  active lines of the last reported frame
//   frame_crc    CRC-16/CCITT (0x1021, init 0xFFFF) of that frame's pixels
//   frame_count  number of reported frames since reset (wraps)
//   locked       two consecutive reports had the same nonzero geometry
//   err          sticky flags: [0] line width, [1] x step, [2] lost lock
module video_frame_check #(
    parameter int BPC   = 5,
    parameter int CORDW = 16
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic signed [CORDW-1:0] disp_x,
    input  logic                    disp_de,
    input  logic                    disp_frame,
    input  logic [BPC-1:0]          disp_r,
    input  logic [BPC-1:0]          disp_g,
    input  logic [BPC-1:0]          disp_b,
    input  logic                    err_clr,
    output logic                    frame_done,
    output logic [CORDW-1:0]        meas_width,
    output logic [CORDW-1:0]        meas_height,
    output logic [15:0]             frame_crc,
    output logic [15:0]             frame_count,
    output logic                    locked,
    output logic [2:0]              err
);

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t state, state_nxt;

    // Per-frame accumulation state
    logic                    de_q, de_q_nxt;
    logic signed [CORDW-1:0] x_q, x_q_nxt;
    logic [CORDW-1:0]        line_len, line_len_nxt;
    logic [CORDW-1:0]        line_cnt, line_cnt_nxt;
    logic [CORDW-1:0]        ref_width, ref_width_nxt;
    logic                    ref_set, ref_set_nxt;
    logic [15:0]             crc, crc_nxt;
    logic [CORDW-1:0]        prev_w, prev_w_nxt;
    logic [CORDW-1:0]        prev_h, prev_h_nxt;

    // Next values of the registered outputs
    logic                    frame_done_nxt;
    logic [CORDW-1:0]        meas_width_nxt;
    logic [CORDW-1:0]        meas_height_nxt;
    logic [15:0]             frame_crc_nxt;
    logic [15:0]             frame_count_nxt;
    logic                    locked_nxt;
    logic [2:0]              err_nxt;

    logic [2:0]              err_new;
    logic                    line_close;
    logic                    geom_same;
    logic signed [CORDW-1:0] x_inc;
    logic [15:0]             pix_word;

    assign x_inc    = x_q + CORDW'(1);
    assign pix_word = 16'({disp_r, disp_g, disp_b});

    // One 16-bit word into the CRC, MSB first
    function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [15:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ CRC_POLY;
        end
        return c;
    endfunction

    function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v);
        return (&v) ? v : v + CORDW'(1);
    endfunction

    // State register
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next state: the first frame strobe arms the checker for good
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (disp_frame) state_nxt = S_ACTIVE;
            S_ACTIVE: state_nxt = S_ACTIVE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        de_q_nxt        = disp_de & ((state == S_ACTIVE) | disp_frame);
        x_q_nxt         = disp_x;
        line_len_nxt    = line_len;
        line_cnt_nxt    = line_cnt;
        ref_width_nxt   = ref_width;
        ref_set_nxt     = ref_set;
        crc_nxt         = crc;
        prev_w_nxt      = prev_w;
        prev_h_nxt      = prev_h;
        frame_done_nxt  = 1'b0;
        meas_width_nxt  = meas_width;
        meas_height_nxt = meas_height;
        frame_crc_nxt   = frame_crc;
        frame_count_nxt = frame_count;
        locked_nxt      = locked;
        err_new         = 3'b000;
        line_close      = 1'b0;
        geom_same       = 1'b0;

        if (state == S_ACTIVE) begin
            // A run ends on a falling DE or on a frame strobe that takes the pixel
            line_close = de_q & (~disp_de | disp_frame);
            if (line_close) begin
                if (!ref_set) begin
                    ref_width_nxt = line_len;
                    ref_set_nxt   = 1'b1;
                end else if (line_len != ref_width) begin
                    err_new[0] = 1'b1;
                end
            end

            if (de_q && disp_de && !disp_frame && (disp_x != x_inc))
                err_new[1] = 1'b1;

            // Report uses the reference width including a line closed this cycle
            if (disp_frame) begin
                frame_done_nxt  = 1'b1;
                meas_width_nxt  = ref_width_nxt;
                meas_height_nxt = line_cnt;
                frame_crc_nxt   = crc;
                frame_count_nxt = frame_count + 16'd1;
                geom_same       = (ref_width_nxt == prev_w) && (line_cnt == prev_h);
                if (geom_same) begin
                    if ((ref_width_nxt != '0) && (line_cnt != '0)) locked_nxt = 1'b1;
                end else begin
                    locked_nxt = 1'b0;
                    if (locked) err_new[2] = 1'b1;
                end
                prev_w_nxt = ref_width_nxt;
                prev_h_nxt = line_cnt;
            end
        end

        // A pixel coincident with the strobe seeds the new frame
        if (disp_frame) begin
            ref_width_nxt = '0;
            ref_set_nxt   = 1'b0;
            if (disp_de) begin
                line_len_nxt = CORDW'(1);
                line_cnt_nxt = CORDW'(1);
                crc_nxt      = crc_step(CRC_INIT, pix_word);
            end else begin
                line_len_nxt = '0;
                line_cnt_nxt = '0;
                crc_nxt      = CRC_INIT;
            end
        end else if ((state == S_ACTIVE) && disp_de) begin
            if (de_q) begin
                line_len_nxt = sat_inc(line_len);
            end else begin
                line_len_nxt = CORDW'(1);
                line_cnt_nxt = sat_inc(line_cnt);
            end
            crc_nxt = crc_step(crc, pix_word);
        end

        // A new error wins over a simultaneous clear
        err_nxt = (err & ~{3{err_clr}}) | err_new;
    end

    // Datapath and output registers
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            de_q        <= 1'b0;
            x_q         <= '0;
            line_len    <= '0;
            line_cnt    <= '0;
            ref_width   <= '0;
            ref_set     <= 1'b0;
            crc         <= CRC_INIT;
            prev_w      <= '0;
            prev_h      <= '0;
            frame_done  <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
            frame_crc   <= CRC_INIT;
            frame_count <= '0;
            locked      <= 1'b0;
            err         <= 3'b000;
        end else begin
            de_q        <= de_q_nxt;
            x_q         <= x_q_nxt;
            line_len    <= line_len_nxt;
            line_cnt    <= line_cnt_nxt;
            ref_width   <= ref_width_nxt;
            ref_set     <= ref_set_nxt;
            crc         <= crc_nxt;
            prev_w      <= prev_w_nxt;
            prev_h      <= prev_h_nxt;
            frame_done  <= frame_done_nxt;
            meas_width  <= meas_width_nxt;
            meas_height <= meas_height_nxt;
            frame_crc   <= frame_crc_nxt;
            frame_count <= frame_count_nxt;
            locked      <= locked_nxt;
            err         <= err_nxt;
        end
    end

endmodule

// File: tb/tb_video_frame_check.sv
// Testbench for video_frame_check: table of whole-frame vectors plus
// hand-written sequences for strobe/DE coincidence, async reset and
// counter saturation (second instance with a 4-bit coordinate width).
module tb_video_frame_check;

    localparam int BPC     = 5;
    localparam int CORDW   = 16;
    localparam int CORDW_S = 4;

    logic                    clk_pix = 1'b0;
    logic                    rst_pix;
    logic signed [CORDW-1:0] disp_x;
    logic                    disp_de;
    logic                    disp_frame;
    logic [BPC-1:0]          disp_r, disp_g, disp_b;
    logic                    err_clr;
    logic                    frame_done;
    logic [CORDW-1:0]        meas_width, meas_height;
    logic [15:0]             frame_crc, frame_count;
    logic                    locked;
    logic [2:0]              err;

    logic signed [CORDW_S-1:0] x_s;
    logic                      s_frame_done;
    logic [CORDW_S-1:0]        s_meas_width, s_meas_height;
    logic [15:0]               s_frame_crc, s_frame_count;
    logic                      s_locked;
    logic [2:0]                s_err;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_crc;
    logic [15:0] saved_crc;

    always #5 clk_pix = ~clk_pix;

    assign x_s = CORDW_S'(disp_x);

    video_frame_check #(.BPC(BPC), .CORDW(CORDW)) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .disp_x(disp_x), .disp_de(disp_de),
        .disp_frame(disp_frame), .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b),
        .err_clr(err_clr), .frame_done(frame_done), .meas_width(meas_width),
        .meas_height(meas_height), .frame_crc(frame_crc), .frame_count(frame_count),
        .locked(locked), .err(err)
    );

    video_frame_check #(.BPC(BPC), .CORDW(CORDW_S)) dut_s (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .disp_x(x_s), .disp_de(disp_de),
        .disp_frame(disp_frame), .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b),
        .err_clr(err_clr), .frame_done(s_frame_done), .meas_width(s_meas_width),
        .meas_height(s_meas_height), .frame_crc(s_frame_crc), .frame_count(s_frame_count),
        .locked(s_locked), .err(s_err)
    );

    typedef struct {
        int          w;
        int          h;
        int          short_row;
        int          skip_row;
        bit          zero_pix;
        bit          clr;
        bit          exp_done;
        int          exp_w;
        int          exp_h;
        int          exp_cnt;
        bit          exp_lock;
        logic [2:0]  exp_err;
        int          exp_crc;
    } vec_t;

    vec_t vecs[10];

    // Reference CRC-16/CCITT: xor the word in, then 16 shift/reduce steps
    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [15:0] w);
        logic [15:0] c;
        c = c_in ^ w;
        for (int k = 0; k < 16; k++)
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic set_pix(input int row, input int col, input int xv, input bit zero_pix);
        disp_de = 1'b1;
        disp_x  = CORDW'(xv);
        if (zero_pix) begin
            disp_r = '0; disp_g = '0; disp_b = '0;
        end else begin
            disp_r = BPC'(row * 7 + col * 3 + 5);
            disp_g = BPC'(row * 11 + col * 5 + 1);
            disp_b = BPC'(row * 13 + col * 17 + 9);
        end
    endtask

    function automatic logic [15:0] cur_word();
        return 16'({disp_r, disp_g, disp_b});
    endfunction

    task automatic send_body(input int w, input int h, input int short_row, input int skip_row,
                             input bit zero_pix);
        int len;
        model_crc = 16'hFFFF;
        for (int row = 0; row < h; row++) begin
            len = (row == short_row) ? w - 1 : w;
            for (int col = 0; col < len; col++) begin
                set_pix(row, col, (row == skip_row && col >= 2) ? col + 1 : col, zero_pix);
                model_crc = crc_model(model_crc, cur_word());
                tick();
                if (row == skip_row && col == 2) check("err1_after_x_skip", err[1], 1'b1);
            end
            disp_de = 1'b0;
            tick();
            if (row == short_row) check("err0_short_line", err[0], 1'b1);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // {w, h, short_row, skip_row, zero_pix, clr, exp_done, exp_w, exp_h, exp_cnt, exp_lock, exp_err, exp_crc}
        // exp_crc < 0 means the bench CRC model of the previous body.
        // 16 zero bits from 0xFFFF give 0x1D0F (0xE1F0 is the value after only 8 zero bits).
        vecs[0] = '{4, 3, -1, -1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 3'b000, -1};
        vecs[1] = '{4, 3, -1, -1, 1'b0, 1'b0, 1'b1, 4, 3, 1, 1'b0, 3'b000, -1};
        vecs[2] = '{4, 3,  1, -1, 1'b0, 1'b0, 1'b1, 4, 3, 2, 1'b1, 3'b000, -1};
        vecs[3] = '{4, 3, -1,  2, 1'b0, 1'b0, 1'b1, 4, 3, 3, 1'b1, 3'b001, -1};
        vecs[4] = '{5, 3, -1, -1, 1'b0, 1'b1, 1'b1, 4, 3, 4, 1'b1, 3'b000, -1};
        vecs[5] = '{5, 3, -1, -1, 1'b0, 1'b0, 1'b1, 5, 3, 5, 1'b0, 3'b100, -1};
        vecs[6] = '{0, 0, -1, -1, 1'b0, 1'b0, 1'b1, 5, 3, 6, 1'b1, 3'b100, -1};
        vecs[7] = '{1, 1, -1, -1, 1'b1, 1'b1, 1'b1, 0, 0, 7, 1'b0, 3'b100, 'hFFFF};
        vecs[8] = '{1, 1, -1, -1, 1'b1, 1'b0, 1'b1, 1, 1, 8, 1'b0, 3'b100, 'h1D0F};
        vecs[9] = '{0, 0, -1, -1, 1'b0, 1'b0, 1'b1, 1, 1, 9, 1'b1, 3'b100, 'h1D0F};

        rst_pix = 1'b1; disp_x = '0; disp_de = 1'b0; disp_frame = 1'b0;
        disp_r = '0; disp_g = '0; disp_b = '0; err_clr = 1'b0;
        model_crc = 16'hFFFF;
        tick(); tick();
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_err", err, 3'b000);
        check("rst_width", meas_width, 0);
        check("rst_height", meas_height, 0);
        check("rst_crc", frame_crc, 16'hFFFF);
        check("rst_count", frame_count, 0);
        rst_pix = 1'b0;
        tick();

        // Frame-level vectors
        for (int i = 0; i < 10; i++) begin
            disp_frame = 1'b1; err_clr = vecs[i].clr;
            tick();
            disp_frame = 1'b0; err_clr = 1'b0;
            check("vec_done", frame_done, vecs[i].exp_done);
            if (vecs[i].exp_done) begin
                check("vec_width", meas_width, vecs[i].exp_w);
                check("vec_height", meas_height, vecs[i].exp_h);
                check("vec_count", frame_count, vecs[i].exp_cnt);
                check("vec_locked", locked, vecs[i].exp_lock);
                check("vec_err", err, vecs[i].exp_err);
                check("vec_crc", frame_crc,
                      (vecs[i].exp_crc < 0) ? 32'(model_crc) : 32'(vecs[i].exp_crc));
            end
            tick();
            check("vec_done_one_cycle", frame_done, 1'b0);
            send_body(vecs[i].w, vecs[i].h, vecs[i].short_row, vecs[i].skip_row, vecs[i].zero_pix);
        end

        // Strobe coincident with DE: open line closes into the old frame
        disp_frame = 1'b1; tick(); disp_frame = 1'b0;
        check("empty_width", meas_width, 0);
        check("empty_height", meas_height, 0);
        check("empty_crc", frame_crc, 16'hFFFF);
        model_crc = 16'hFFFF;
        for (int col = 0; col < 3; col++) begin
            set_pix(0, col, col, 1'b0); model_crc = crc_model(model_crc, cur_word()); tick();
        end
        disp_de = 1'b0; tick(); tick();
        for (int col = 0; col < 3; col++) begin
            set_pix(1, col, col, 1'b0); model_crc = crc_model(model_crc, cur_word()); tick();
        end
        disp_frame = 1'b1; set_pix(2, 0, 0, 1'b0);
        saved_crc = crc_model(16'hFFFF, cur_word());
        tick();
        disp_frame = 1'b0;
        check("coin_done", frame_done, 1'b1);
        check("coin_width", meas_width, 3);
        check("coin_height", meas_height, 2);
        check("coin_crc", frame_crc, model_crc);
        model_crc = saved_crc;
        for (int col = 1; col < 3; col++) begin
            set_pix(2, col, col, 1'b0); model_crc = crc_model(model_crc, cur_word()); tick();
        end
        disp_de = 1'b0; tick();
        for (int col = 0; col < 3; col++) begin
            set_pix(3, col, col, 1'b0); model_crc = crc_model(model_crc, cur_word()); tick();
        end
        disp_de = 1'b0; tick();
        disp_frame = 1'b1; tick(); disp_frame = 1'b0;
        check("seed_width", meas_width, 3);
        check("seed_height", meas_height, 2);
        check("seed_crc", frame_crc, model_crc);
        check("seed_err_low", err[1:0], 2'b00);

        // Asynchronous reset in the middle of a line
        set_pix(0, 0, 0, 1'b0); tick();
        set_pix(0, 1, 1, 1'b0); tick();
        #4 rst_pix = 1'b1;
        #1;
        check("arst_frame_done", frame_done, 1'b0);
        check("arst_locked", locked, 1'b0);
        check("arst_err", err, 3'b000);
        check("arst_width", meas_width, 0);
        check("arst_height", meas_height, 0);
        check("arst_crc", frame_crc, 16'hFFFF);
        check("arst_count", frame_count, 0);
        tick(); tick();
        rst_pix = 1'b0;
        for (int col = 2; col < 5; col++) begin
            set_pix(0, col, col, 1'b0); tick();
        end
        disp_de = 1'b0; tick();
        disp_frame = 1'b1; tick(); disp_frame = 1'b0;
        check("arst_first_strobe_no_done", frame_done, 1'b0);
        send_body(2, 2, -1, -1, 1'b0);
        disp_frame = 1'b1; tick(); disp_frame = 1'b0;
        check("arst_done", frame_done, 1'b1);
        check("arst_rep_width", meas_width, 2);
        check("arst_rep_height", meas_height, 2);
        check("arst_rep_count", frame_count, 1);
        check("arst_rep_crc", frame_crc, model_crc);

        // Saturation: 20x20 frame against a 4-bit coordinate instance
        send_body(20, 20, -1, -1, 1'b0);
        disp_frame = 1'b1; tick(); disp_frame = 1'b0;
        check("big_width", meas_width, 20);
        check("big_height", meas_height, 20);
        check("big_count", frame_count, 2);
        check("big_crc", frame_crc, model_crc);
        check("big_err", err, 3'b000);
        check("sat_done", s_frame_done, 1'b1);
        check("sat_width", s_meas_width, 15);
        check("sat_height", s_meas_height, 15);
        check("sat_count", s_frame_count, 2);
        check("sat_crc", s_frame_crc, model_crc);
        check("sat_locked", s_locked, 1'b0);
        check("sat_err", s_err, 3'b000);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
